// File: rtl/video_vram_port.sv
// Host-side VRAM access port: scroll/address registers (t, v, x, w), the PPUDATA
// access sequencer against a synchronous video RAM, and the one-deep read buffer.
module video_vram_port (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_host_wr,
    input  logic        I_host_rd,
    input  logic [2:0]  I_host_addr,
    input  logic [7:0]  I_host_data,
    input  logic        I_incr_32,
    output logic [7:0]  O_host_data,
    output logic        O_busy,
    output logic [13:0] O_vid_addr,
    output logic        O_vid_wren,
    input  logic [7:0]  I_vid_data,
    output logic [7:0]  O_vid_data,
    output logic [14:0] O_scroll_t,
    output logic [14:0] O_scroll_v,
    output logic [2:0]  O_fine_x
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [14:0] r_t;
    logic [14:0] r_v;
    logic [2:0]  r_x;
    logic        r_w;
    logic [7:0]  r_buf;
    logic [7:0]  r_host_data;
    logic [13:0] r_vid_addr;
    logic [7:0]  r_vid_data;

    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_rd_status;
    logic        w_wr_scroll;
    logic        w_wr_addr;
    logic        w_wr_data;
    logic        w_rd_data;
    logic        w_idle;
    logic        w_acc_wr;
    logic        w_acc_rd;

    logic [14:0] w_t_nxt;
    logic [2:0]  w_x_nxt;
    logic        w_w_nxt;
    logic        w_v_load;
    logic [14:0] w_v_base;
    logic [14:0] w_step;
    logic        w_v_inc;
    logic [14:0] w_v_nxt;

    // A simultaneous write wins; the read (and its status-side effect) is discarded.
    assign w_rd        = I_host_rd & ~I_host_wr;
    assign w_wr_ctrl   = I_host_wr && (I_host_addr == 3'd0);
    assign w_rd_status = w_rd      && (I_host_addr == 3'd2);
    assign w_wr_scroll = I_host_wr && (I_host_addr == 3'd5);
    assign w_wr_addr   = I_host_wr && (I_host_addr == 3'd6);
    assign w_wr_data   = I_host_wr && (I_host_addr == 3'd7);
    assign w_rd_data   = w_rd      && (I_host_addr == 3'd7);

    assign w_idle   = (r_state == S_IDLE);
    assign w_acc_wr = w_wr_data & w_idle;
    assign w_acc_rd = w_rd_data & w_idle;

    always_comb begin
        w_t_nxt  = r_t;
        w_x_nxt  = r_x;
        w_w_nxt  = r_w;
        w_v_load = 1'b0;
        if (w_wr_ctrl) begin
            w_t_nxt[11:10] = I_host_data[1:0];
        end else if (w_rd_status) begin
            w_w_nxt = 1'b0;
        end else if (w_wr_scroll) begin
            if (!r_w) begin
                w_t_nxt[4:0] = I_host_data[7:3];
                w_x_nxt      = I_host_data[2:0];
                w_w_nxt      = 1'b1;
            end else begin
                w_t_nxt[14:12] = I_host_data[2:0];
                w_t_nxt[9:5]   = I_host_data[7:3];
                w_w_nxt        = 1'b0;
            end
        end else if (w_wr_addr) begin
            if (!r_w) begin
                w_t_nxt[13:8] = I_host_data[5:0];
                w_t_nxt[14]   = 1'b0;
                w_w_nxt       = 1'b1;
            end else begin
                w_t_nxt[7:0] = I_host_data;
                w_w_nxt      = 1'b0;
                w_v_load     = 1'b1;
            end
        end
    end

    // An address load coinciding with an access exit is incremented from the new value.
    assign w_step   = I_incr_32 ? 15'd32 : 15'd1;
    assign w_v_base = w_v_load ? w_t_nxt : r_v;
    assign w_v_inc  = (r_state == S_WR) || (r_state == S_RD_ADDR);
    assign w_v_nxt  = w_v_inc ? (w_v_base + w_step) : w_v_base;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_acc_wr) begin
                    w_state_nxt = S_WR;
                end else if (w_acc_rd) begin
                    w_state_nxt = S_RD_ADDR;
                end
            end
            S_WR:      w_state_nxt = S_IDLE;
            S_RD_ADDR: w_state_nxt = S_RD_DATA;
            S_RD_DATA: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_t <= 15'd0;
            r_v <= 15'd0;
            r_x <= 3'd0;
            r_w <= 1'b0;
        end else begin
            r_t <= w_t_nxt;
            r_v <= w_v_nxt;
            r_x <= w_x_nxt;
            r_w <= w_w_nxt;
        end
    end

    // Bus address/data are latched at the strobe and held until the next accepted access.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            r_vid_addr  <= 14'd0;
            r_vid_data  <= 8'd0;
            r_host_data <= 8'd0;
            r_buf       <= 8'd0;
        end else begin
            if (w_acc_wr) begin
                r_vid_addr <= r_v[13:0];
                r_vid_data <= I_host_data;
            end
            if (w_acc_rd) begin
                r_vid_addr  <= r_v[13:0];
                r_host_data <= r_buf;
            end
            if (r_state == S_RD_DATA) begin
                r_buf <= I_vid_data;
            end
        end
    end

    assign O_busy      = ~w_idle;
    assign O_vid_wren  = (r_state == S_WR);
    assign O_vid_addr  = r_vid_addr;
    assign O_vid_data  = r_vid_data;
    assign O_host_data = r_host_data;
    assign O_scroll_t  = r_t;
    assign O_scroll_v  = r_v;
    assign O_fine_x    = r_x;

endmodule

// File: tb/tb_video_vram_port.sv
// Directed bench for video_vram_port with a synchronous RAM model on the video bus.
module tb_video_vram_port;

    logic        clk;
    logic        rst;
    logic        host_wr;
    logic        host_rd;
    logic [2:0]  host_addr;
    logic [7:0]  host_data;
    logic        incr_32;
    logic [7:0]  host_q;
    logic        busy;
    logic [13:0] vid_addr;
    logic        vid_wren;
    logic [7:0]  vid_rdat;
    logic [7:0]  vid_wdat;
    logic [14:0] scroll_t;
    logic [14:0] scroll_v;
    logic [2:0]  fine_x;

    logic [7:0]  mem [0:16383];

    int n_tests = 0;
    int n_fail  = 0;

    video_vram_port dut (
        .I_clock     (clk),
        .I_reset     (rst),
        .I_host_wr   (host_wr),
        .I_host_rd   (host_rd),
        .I_host_addr (host_addr),
        .I_host_data (host_data),
        .I_incr_32   (incr_32),
        .O_host_data (host_q),
        .O_busy      (busy),
        .O_vid_addr  (vid_addr),
        .O_vid_wren  (vid_wren),
        .I_vid_data  (vid_rdat),
        .O_vid_data  (vid_wdat),
        .O_scroll_t  (scroll_t),
        .O_scroll_v  (scroll_v),
        .O_fine_x    (fine_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vid_wren) mem[vid_addr] <= vid_wdat;
        vid_rdat <= mem[vid_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a strobe for one cycle; returns 1 time unit into the following cycle.
    task automatic strobe(input logic wr, input logic rd, input logic [2:0] a, input logic [7:0] d);
        host_wr   = wr;
        host_rd   = rd;
        host_addr = a;
        host_data = d;
        tick();
        host_wr   = 1'b0;
        host_rd   = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        strobe(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        strobe(1'b0, 1'b1, a, 8'h00);
    endtask

    initial begin
        rst       = 1'b1;
        host_wr   = 1'b0;
        host_rd   = 1'b0;
        host_addr = 3'd0;
        host_data = 8'd0;
        incr_32   = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_wren", vid_wren, 0);
        chk("rst_addr", vid_addr, 0);
        chk("rst_vdat", vid_wdat, 0);
        chk("rst_hdat", host_q, 0);
        chk("rst_t", scroll_t, 0);
        chk("rst_v", scroll_v, 0);
        chk("rst_x", fine_x, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Address load then a single data write
        wr_reg(3'd6, 8'h21);
        chk("t_hi", scroll_t, 15'h2100);
        wr_reg(3'd6, 8'h08);
        chk("t_full", scroll_t, 15'h2108);
        chk("v_load", scroll_v, 15'h2108);
        wr_reg(3'd7, 8'hAB);
        chk("wr_wren", vid_wren, 1);
        chk("wr_busy", busy, 1);
        chk("wr_addr", vid_addr, 14'h2108);
        chk("wr_data", vid_wdat, 8'hAB);
        tick();
        chk("wr_wren_off", vid_wren, 0);
        chk("wr_busy_off", busy, 0);
        chk("wr_v_inc", scroll_v, 15'h2109);
        chk("wr_mem", mem[14'h2108], 8'hAB);
        chk("wr_addr_hold", vid_addr, 14'h2108);

        // Fill RAM through the port, then read back through the buffer
        wr_reg(3'd6, 8'h20);
        wr_reg(3'd6, 8'h00);
        wr_reg(3'd7, 8'h11);
        tick();
        wr_reg(3'd7, 8'h22);
        tick();
        chk("fill_v", scroll_v, 15'h2002);
        wr_reg(3'd6, 8'h20);
        wr_reg(3'd6, 8'h00);
        chk("rd_v0", scroll_v, 15'h2000);
        rd_reg(3'd7);
        chk("rd1_data", host_q, 8'h00);
        chk("rd1_addr", vid_addr, 14'h2000);
        chk("rd1_busy", busy, 1);
        chk("rd1_wren", vid_wren, 0);
        tick();
        chk("rd1_busy2", busy, 1);
        tick();
        chk("rd1_idle", busy, 0);
        rd_reg(3'd7);
        chk("rd2_data", host_q, 8'h11);
        chk("rd2_addr", vid_addr, 14'h2001);
        tick();
        tick();
        rd_reg(3'd7);
        chk("rd3_data", host_q, 8'h22);
        tick();
        tick();
        chk("rd_v_end", scroll_v, 15'h2003);

        // Read strobe during WR is dropped
        wr_reg(3'd7, 8'h55);
        chk("drop_wren", vid_wren, 1);
        rd_reg(3'd7);
        chk("drop_busy", busy, 0);
        chk("drop_v", scroll_v, 15'h2004);
        chk("drop_hdat", host_q, 8'h22);
        tick();
        chk("drop_busy2", busy, 0);
        chk("drop_hdat2", host_q, 8'h22);
        chk("drop_v2", scroll_v, 15'h2004);

        // Increment by 32 across the 14-bit address boundary
        incr_32 = 1'b1;
        wr_reg(3'd6, 8'h3F);
        wr_reg(3'd6, 8'hF0);
        wr_reg(3'd7, 8'h01);
        chk("i32_addr1", vid_addr, 14'h3FF0);
        tick();
        chk("i32_v1", scroll_v, 15'h4010);
        wr_reg(3'd7, 8'h02);
        chk("i32_addr2", vid_addr, 14'h0010);
        tick();
        chk("i32_v2", scroll_v, 15'h4030);
        incr_32 = 1'b0;

        // Build v = 0x7FFF (t[14] only reachable through the scroll register)
        wr_reg(3'd6, 8'h3F);
        wr_reg(3'd5, 8'hFF);
        chk("wrap_t1", scroll_t, 15'h7FF0);
        wr_reg(3'd5, 8'hF8);
        chk("wrap_x", fine_x, 3'd0);
        wr_reg(3'd6, 8'hFF);
        chk("wrap_v0", scroll_v, 15'h7FFF);
        wr_reg(3'd7, 8'h03);
        chk("wrap_addr", vid_addr, 14'h3FFF);
        tick();
        chk("wrap_v", scroll_v, 15'h0000);

        // Scroll register sequence; w is 0 here
        wr_reg(3'd5, 8'h7D);
        chk("sc_x", fine_x, 3'd5);
        chk("sc_tlo", {27'd0, scroll_t[4:0]}, 32'h0F);
        strobe(1'b1, 1'b1, 3'd2, 8'h00);
        wr_reg(3'd5, 8'h5E);
        chk("sc_t1412", {29'd0, scroll_t[14:12]}, 32'd6);
        chk("sc_t95", {27'd0, scroll_t[9:5]}, 32'h0B);
        chk("sc_x_keep", fine_x, 3'd5);
        wr_reg(3'd5, 8'h7D);
        rd_reg(3'd2);
        wr_reg(3'd5, 8'h7D);
        chk("sc_w_clr", {29'd0, scroll_t[14:12]}, 32'd6);
        wr_reg(3'd0, 8'h03);
        chk("sc_t_final", scroll_t, 15'h6D6F);

        // Reset during WR aborts the access
        rd_reg(3'd2);
        wr_reg(3'd6, 8'h12);
        wr_reg(3'd6, 8'h34);
        chk("ra_v0", scroll_v, 15'h1234);
        wr_reg(3'd7, 8'h99);
        chk("ra_wren", vid_wren, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ra_wren_off", vid_wren, 0);
        chk("ra_busy", busy, 0);
        chk("ra_v", scroll_v, 0);
        chk("ra_t", scroll_t, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("ra_v_after", scroll_v, 0);
        chk("ra_busy_after", busy, 0);
        chk("ra_hdat", host_q, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
